// File: rtl/rca_pkg.sv
// Shared types and helpers for the nibble-serial ripple-carry add sequencer.
package rca_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rca_ctrl_state_t;

    function automatic int nibs(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder: Sum/Cout = A + B + Cin.
module ripple_carry_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic carry_s;

    // Four chained full adders.
    always_comb begin
        Sum     = 4'd0;
        carry_s = Cin;
        for (int i = 0; i < 4; i++) begin
            Sum[i]  = A[i] ^ B[i] ^ carry_s;
            carry_s = (A[i] & B[i]) | (carry_s & (A[i] ^ B[i]));
        end
        Cout = carry_s;
    end

endmodule

// File: rtl/rca_serial_add_ctrl.sv
// WIDTH-bit adder built from one 4-bit ripple-carry adder stepped over NIBS
// clocks, LSB nibble first, with valid/ready handshakes on both sides.
module rca_serial_add_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBS  = nibs(WIDTH);
    localparam int IDX_W = $clog2(NIBS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

    if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_width_check
        $error("rca_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    rca_ctrl_state_t  state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIB_W-1:0] nib_sum_s;
    logic             nib_cout_s;
    logic [WIDTH-1:0] acc_next_s;

    ripple_carry_adder u_rca (
        .A    (a_sh_q[NIB_W-1:0]),
        .B    (b_sh_q[NIB_W-1:0]),
        .Cin  (carry_q),
        .Sum  (nib_sum_s),
        .Cout (nib_cout_s)
    );

    // On the last step this is the complete result.
    assign acc_next_s = {nib_sum_s, acc_q[WIDTH-1:NIB_W]};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Next-state and datapath update for the nibble sequencer.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> NIB_W;
                b_sh_d  = b_sh_q >> NIB_W;
                acc_d   = acc_next_s;
                carry_d = nib_cout_s;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    sum_d   = acc_next_s;
                    cout_d  = nib_cout_s;
                    ovf_d   = (a_msb_q == b_msb_q) && (acc_next_s[WIDTH-1] != a_msb_q);
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                // Release only; a new accept waits for the following IDLE cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
